// File: rtl/seqdiv.sv
// Sequential signed restoring divider: one quotient bit per clock, sign/overflow
// fix-up in a final cycle, level-sensitive arm handshake with abort.
module seqdiv #(
   parameter int DIVIDEND_LEN = 32,
   parameter int DIVISOR_LEN  = 32,
   parameter int CNT_SIZ      = 6
) (
   input  logic                    clk,
   input  logic                    rst_L,
   input  logic                    arm,
   input  logic [DIVIDEND_LEN-1:0] dividend,
   input  logic [DIVISOR_LEN-1:0]  divisor,
   output logic [DIVIDEND_LEN-1:0] quotient,
   output logic [DIVISOR_LEN-1:0]  remainder,
   output logic                    dbz,
   output logic                    ovf,
   output logic                    fin
);

   localparam int N = DIVIDEND_LEN;
   localparam int M = DIVISOR_LEN;
   localparam logic [CNT_SIZ-1:0] LAST_STEP = CNT_SIZ'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Divide-by-zero remainder: dividend resized to divisor width, sign-extended when wider.
   function automatic logic [M-1:0] dbz_rem(input logic [N-1:0] d);
      logic signed [N-1:0] d_s;
      d_s = d;
      return M'(d_s);
   endfunction

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_SIZ-1:0]  r_cnt;
   logic [N-1:0]        r_q;
   logic [M-1:0]        r_dvs;
   logic [M:0]          r_prem;
   logic                r_sign_n;
   logic                r_sign_d;
   logic                r_dbz_p;
   logic [N-1:0]        r_quot;
   logic [M-1:0]        r_rem;
   logic                r_dbz;
   logic                r_ovf;
   logic                r_fin;

   logic                w_load;
   logic                w_step;
   logic                w_fix;
   logic                w_dvs_zero;
   logic [N-1:0]        w_dvd_mag;
   logic [M-1:0]        w_dvs_mag;
   logic [M+1:0]        w_shift;
   logic                w_ge;
   logic [M:0]          w_diff;
   logic                w_sign_diff;
   logic                w_ovf;

   assign w_dvs_zero  = (divisor == {M{1'b0}});
   assign w_dvd_mag   = dividend[N-1] ? (~dividend + {{(N-1){1'b0}}, 1'b1}) : dividend;
   assign w_dvs_mag   = divisor[M-1]  ? (~divisor  + {{(M-1){1'b0}}, 1'b1}) : divisor;
   // Restoring step: bring in the next dividend bit, subtract the divisor when it fits.
   assign w_shift     = {r_prem, r_q[N-1]};
   assign w_ge        = (w_shift >= {2'b00, r_dvs});
   assign w_diff      = w_shift[M:0] - {1'b0, r_dvs};
   assign w_sign_diff = r_sign_n ^ r_sign_d;
   // Same signs with the magnitude MSB set means a positive quotient past the signed range.
   assign w_ovf       = ~w_sign_diff & r_q[N-1];

   // State register.
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and datapath strobes; arm low always wins and returns to IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_fix       = 1'b0;
      if (!arm) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               w_load      = 1'b1;
               w_state_nxt = w_dvs_zero ? FIX : ITER;
            end
            ITER: begin
               w_step = 1'b1;
               if (r_cnt == LAST_STEP) begin
                  w_state_nxt = FIX;
               end else begin
                  w_state_nxt = ITER;
               end
            end
            FIX: begin
               w_fix       = 1'b1;
               w_state_nxt = DONE;
            end
            DONE: begin
               w_state_nxt = DONE;
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   // Operand latch and iteration datapath.
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         r_cnt    <= {CNT_SIZ{1'b0}};
         r_q      <= {N{1'b0}};
         r_dvs    <= {M{1'b0}};
         r_prem   <= {(M+1){1'b0}};
         r_sign_n <= 1'b0;
         r_sign_d <= 1'b0;
         r_dbz_p  <= 1'b0;
      end else if (w_load) begin
         r_cnt    <= {CNT_SIZ{1'b0}};
         r_q      <= w_dvs_zero ? dividend : w_dvd_mag;
         r_dvs    <= w_dvs_mag;
         r_prem   <= {(M+1){1'b0}};
         r_sign_n <= dividend[N-1];
         r_sign_d <= divisor[M-1];
         r_dbz_p  <= w_dvs_zero;
      end else if (w_step) begin
         r_cnt  <= r_cnt + {{(CNT_SIZ-1){1'b0}}, 1'b1};
         r_prem <= w_ge ? w_diff : w_shift[M:0];
         r_q    <= {r_q[N-2:0], w_ge};
      end else begin
         r_cnt <= r_cnt;
      end
   end

   // Result registers: written once in FIX, flags cleared whenever arm is low.
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         r_quot <= {N{1'b0}};
         r_rem  <= {M{1'b0}};
         r_dbz  <= 1'b0;
         r_ovf  <= 1'b0;
         r_fin  <= 1'b0;
      end else if (!arm) begin
         r_dbz <= 1'b0;
         r_ovf <= 1'b0;
         r_fin <= 1'b0;
      end else if (w_fix) begin
         r_fin <= 1'b1;
         if (r_dbz_p) begin
            r_quot <= {N{1'b0}};
            r_rem  <= dbz_rem(r_q);
            r_dbz  <= 1'b1;
            r_ovf  <= 1'b0;
         end else if (w_ovf) begin
            r_quot <= r_q;
            r_rem  <= {M{1'b0}};
            r_dbz  <= 1'b0;
            r_ovf  <= 1'b1;
         end else begin
            r_quot <= w_sign_diff ? (~r_q + {{(N-1){1'b0}}, 1'b1}) : r_q;
            r_rem  <= r_sign_n ? (~r_prem[M-1:0] + {{(M-1){1'b0}}, 1'b1}) : r_prem[M-1:0];
            r_dbz  <= 1'b0;
            r_ovf  <= 1'b0;
         end
      end else begin
         r_fin <= r_fin;
      end
   end

   assign quotient  = r_quot;
   assign remainder = r_rem;
   assign dbz       = r_dbz;
   assign ovf       = r_ovf;
   assign fin       = r_fin;

endmodule

// File: tb/tb_seqdiv.sv
// Directed bench for seqdiv at 8/8 widths: latency, signs, overflow, divide-by-zero,
// abort/re-arm and asynchronous reset, with hand-computed expected results.
module tb_seqdiv;

   logic       clk;
   logic       rst_L;
   logic       arm;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       dbz;
   logic       ovf;
   logic       fin;

   int pass_cnt;
   int total_cnt;

   seqdiv #(.DIVIDEND_LEN(8), .DIVISOR_LEN(8), .CNT_SIZ(6)) dut (
      .clk(clk), .rst_L(rst_L), .arm(arm), .dividend(dividend), .divisor(divisor),
      .quotient(quotient), .remainder(remainder), .dbz(dbz), .ovf(ovf), .fin(fin)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Return to IDLE, load a/b, scramble operands after the load edge, run lat edges.
   task automatic run_div(input logic [7:0] a, input logic [7:0] b, input int lat,
                          output int early);
      early = 0;
      arm = 1'b0;
      tick();
      dividend = a;
      divisor  = b;
      arm      = 1'b1;
      for (int k = 1; k <= lat; k++) begin
         tick();
         if (k == 1) begin
            dividend = 8'h5A;
            divisor  = 8'h03;
         end
         if (k < lat && fin) early++;
      end
   endtask

   task automatic check_result(input string name, input int early,
                               input logic [7:0] eq, input logic [7:0] er,
                               input logic edbz, input logic eovf);
      total_cnt++;
      if (early !== 0 || fin !== 1'b1) begin
         $display("FAIL %s latency: early fin=%0d fin=%b, want 0 and 1", name, early, fin);
      end else pass_cnt++;
      total_cnt++;
      if ({quotient, remainder, dbz, ovf} !== {eq, er, edbz, eovf}) begin
         $display("FAIL %s result: q=%h r=%h dbz=%b ovf=%b, want q=%h r=%h dbz=%b ovf=%b",
                  name, quotient, remainder, dbz, ovf, eq, er, edbz, eovf);
      end else pass_cnt++;
   endtask

   task automatic test_reset();
      rst_L = 1'b0;
      arm = 1'b1;
      dividend = 8'd100;
      divisor = 8'd7;
      #3;
      total_cnt++;
      if ({quotient, remainder, dbz, ovf, fin} !== 19'h0) begin
         $display("FAIL reset_state: q=%h r=%h dbz=%b ovf=%b fin=%b, want all 0",
                  quotient, remainder, dbz, ovf, fin);
      end else pass_cnt++;
      tick();
      tick();
      total_cnt++;
      if (fin !== 1'b0) $display("FAIL reset_hold: fin=%b want 0", fin);
      else pass_cnt++;
      arm = 1'b0;
      #2 rst_L = 1'b1;
   endtask

   task automatic test_basic();
      int early;
      run_div(8'd100, 8'd7, 10, early);
      check_result("100/7", early, 8'h0E, 8'h02, 1'b0, 1'b0);
      dividend = 8'd1;
      divisor = 8'd1;
      for (int k = 0; k < 3; k++) tick();
      total_cnt++;
      if ({fin, quotient, remainder} !== {1'b1, 8'h0E, 8'h02}) begin
         $display("FAIL done_hold: fin=%b q=%h r=%h, want 1 0e 02", fin, quotient, remainder);
      end else pass_cnt++;
   endtask

   task automatic test_signs();
      int early;
      run_div(8'd156, 8'd7, 10, early);    // -100 / 7
      check_result("-100/7", early, 8'hF2, 8'hFE, 1'b0, 1'b0);
      run_div(8'd100, 8'hF9, 10, early);   // 100 / -7
      check_result("100/-7", early, 8'hF2, 8'h02, 1'b0, 1'b0);
      run_div(8'd156, 8'hF9, 10, early);   // -100 / -7
      check_result("-100/-7", early, 8'h0E, 8'hFE, 1'b0, 1'b0);
   endtask

   task automatic test_ovf();
      int early;
      run_div(8'h80, 8'hFF, 10, early);
      check_result("-128/-1", early, 8'h80, 8'h00, 1'b0, 1'b1);
      run_div(8'h80, 8'h01, 10, early);
      check_result("-128/1", early, 8'h80, 8'h00, 1'b0, 1'b0);
      run_div(8'h7F, 8'h80, 10, early);
      check_result("127/-128", early, 8'h00, 8'h7F, 1'b0, 1'b0);
      run_div(8'h80, 8'h7F, 10, early);
      check_result("-128/127", early, 8'hFF, 8'hFF, 1'b0, 1'b0);
   endtask

   task automatic test_dbz();
      int early;
      run_div(8'd5, 8'd0, 2, early);
      check_result("5/0", early, 8'h00, 8'h05, 1'b1, 1'b0);
      arm = 1'b0;
      tick();
      total_cnt++;
      if ({dbz, ovf, fin, quotient, remainder} !== {3'b000, 8'h00, 8'h05}) begin
         $display("FAIL ack_clear: dbz=%b ovf=%b fin=%b q=%h r=%h, want 000 00 05",
                  dbz, ovf, fin, quotient, remainder);
      end else pass_cnt++;
      run_div(8'hFD, 8'd0, 2, early);
      check_result("-3/0", early, 8'h00, 8'hFD, 1'b1, 1'b0);
   endtask

   task automatic test_abort();
      int early;
      int fin_seen;
      fin_seen = 0;
      arm = 1'b0;
      tick();
      dividend = 8'd100;
      divisor = 8'd7;
      arm = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (fin) fin_seen++;
      end
      arm = 1'b0;
      tick();
      if (fin) fin_seen++;
      dividend = 8'd9;
      divisor = 8'd2;
      arm = 1'b1;
      early = 0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k < 10 && fin) early++;
      end
      total_cnt++;
      if (fin_seen !== 0) $display("FAIL abort_fin: fin high %0d times, want 0", fin_seen);
      else pass_cnt++;
      check_result("abort_then_9/2", early, 8'h04, 8'h01, 1'b0, 1'b0);
   endtask

   task automatic test_async_reset();
      int early;
      arm = 1'b0;
      tick();
      dividend = 8'd100;
      divisor = 8'd7;
      arm = 1'b1;
      for (int k = 1; k <= 4; k++) tick();
      #2 rst_L = 1'b0;
      #1;
      total_cnt++;
      if ({quotient, remainder, dbz, ovf, fin} !== 19'h0) begin
         $display("FAIL async_reset: q=%h r=%h dbz=%b ovf=%b fin=%b, want all 0",
                  quotient, remainder, dbz, ovf, fin);
      end else pass_cnt++;
      dividend = 8'd20;
      divisor = 8'd3;
      #1 rst_L = 1'b1;
      early = 0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 1) begin
            dividend = 8'hFF;
            divisor = 8'hFF;
         end
         if (k < 10 && fin) early++;
      end
      check_result("post_reset_20/3", early, 8'h06, 8'h02, 1'b0, 1'b0);
   endtask

   initial begin
      pass_cnt = 0;
      total_cnt = 0;
      test_reset();
      test_basic();
      test_signs();
      test_ovf();
      test_dbz();
      test_abort();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
